// File: rtl/imem_boot_pkg.sv
// Shared constants for the instruction-memory boot loader: state encoding,
// header length, write mask and the byte-lane insert helper.
package imem_boot_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StHdr   = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StCsum  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;
    localparam logic [2:0] StError = 3'd5;

    localparam int unsigned HdrBytes = 4;
    localparam logic [3:0]  WordMask = 4'hF;

    typedef logic [31:0] word_t;

    // Little-endian placement: lane 0 lands in bits [7:0].
    function automatic word_t insert_byte(input word_t word, input logic [1:0] lane,
                                          input logic [7:0] data);
        word_t w;
        w = word;
        w[{lane, 3'b000} +: 8] = data;
        return w;
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four accepted bytes into a little-endian 32-bit word; done_o and
// word_o are combinational so the consumer sees the full word on the 4th byte.
module imem_word_assembler
    import imem_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        done_o
);

    localparam int unsigned LaneW = $clog2(HdrBytes);

    logic [LaneW-1:0] lane_q, lane_d;
    word_t            word_q, word_d;

    always_comb begin
        word_o = insert_byte(word_q, lane_q, byte_i);
        done_o = valid_i && (lane_q == LaneW'(HdrBytes - 1));
        lane_d = lane_q;
        word_d = word_q;
        if (clear_i) begin
            lane_d = '0;
        end else if (valid_i) begin
            lane_d = lane_q + LaneW'(1);
            word_d = word_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: length-prefixed byte stream -> instruction memory writes, with
// CPU pause/restart. Optional trailer checksum under IMEM_BOOT_CHECKSUM_EN.
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int unsigned SIZE      = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          AUTO_BOOT = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        boot_req_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_waddr_o,
    output logic [31:0] imem_wdata_o,
    output logic [3:0]  imem_wmask_o,
    output logic        cpu_pause_o,
    output logic        cpu_restart_o,
    output logic        boot_busy_o,
    output logic        boot_err_o
);

`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam logic [2:0] StPostData = StCsum;
`else
    localparam logic [2:0] StPostData = StDone;
`endif
    localparam logic [2:0] StReset = AUTO_BOOT ? StHdr : StIdle;

    logic [2:0]  state_q, state_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        rx_ready_q, rx_ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        pause_q, pause_d;
    logic        restart_q, restart_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic        accept;
    logic        asm_clear;
    logic        asm_done;
    logic [31:0] asm_word;

    assign accept    = rx_valid_i && rx_ready_q;
    assign asm_clear = !(state_q == StHdr || state_q == StData || state_q == StCsum);

    imem_word_assembler u_asm (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (asm_clear),
        .valid_i (accept),
        .byte_i  (rx_data_i),
        .word_o  (asm_word),
        .done_o  (asm_done)
    );

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (boot_req_i) state_d = StHdr;
            end
            StHdr: begin
                if (asm_done) begin
                    word_cnt_d = asm_word;
                    addr_d     = BASE_ADDR;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    if (asm_word == '0) begin
                        state_d = StPostData;
                    end else if (asm_word > 32'(SIZE)) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (asm_done) begin
                    we_d       = 1'b1;
                    waddr_d    = addr_q;
                    wdata_d    = asm_word;
                    addr_d     = addr_q + 32'd4;
                    word_cnt_d = word_cnt_q - 32'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    csum_d     = csum_q + asm_word;
`endif
                end else if (word_cnt_q == '0) begin
                    // Final write is on the bus this cycle; leave afterwards.
                    state_d = StPostData;
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            StCsum: begin
                if (asm_done) state_d = (asm_word == csum_q) ? StDone : StError;
            end
`endif
            StDone: begin
                state_d = boot_req_i ? StHdr : StIdle;
            end
            StError: begin
                if (boot_req_i) state_d = StHdr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status outputs are registered from the next state so they track
        // state_q, except right after reset where they hold reset values.
        busy_d     = (state_d == StHdr) || (state_d == StData) || (state_d == StCsum);
        rx_ready_d = (state_d == StHdr) || (state_d == StCsum) ||
                     ((state_d == StData) && (word_cnt_d != '0));
        err_d      = (state_d == StError);
        pause_d    = (state_d != StIdle);
        restart_d  = (state_d == StDone);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StReset;
            word_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
            waddr_q    <= BASE_ADDR;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            pause_q    <= 1'b1;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            pause_q    <= pause_d;
            restart_q  <= restart_d;
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign rx_ready_o    = rx_ready_q;
    assign imem_we_o     = we_q;
    assign imem_waddr_o  = waddr_q;
    assign imem_wdata_o  = wdata_q;
    assign imem_wmask_o  = we_q ? WordMask : 4'h0;
    assign cpu_pause_o   = pause_q;
    assign cpu_restart_o = restart_q;
    assign boot_busy_o   = busy_q;
    assign boot_err_o    = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized bench for imem_boot_ctrl: a queue-based model predicts every
// memory write and the restart/error outcome of each load.
module tb_imem_boot_ctrl;

    localparam int unsigned SIZE = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        boot_req;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [3:0]  imem_wmask;
    logic        cpu_pause;
    logic        cpu_restart;
    logic        boot_busy;
    logic        boot_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words_q[$];
    logic [7:0]  tx_q[$];

    int n_vec       = 0;
    int n_err       = 0;
    int we_cnt      = 0;
    int restart_cnt = 0;

    imem_boot_ctrl #(
        .SIZE      (SIZE),
        .BASE_ADDR (BASE),
        .AUTO_BOOT (1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .boot_req_i    (boot_req),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .rx_ready_o    (rx_ready),
        .imem_we_o     (imem_we),
        .imem_waddr_o  (imem_waddr),
        .imem_wdata_o  (imem_wdata),
        .imem_wmask_o  (imem_wmask),
        .cpu_pause_o   (cpu_pause),
        .cpu_restart_o (cpu_restart),
        .boot_busy_o   (boot_busy),
        .boot_err_o    (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the next predicted write.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_we", {31'b0, imem_we}, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check_eq("waddr", imem_waddr, e.addr);
                    check_eq("wdata", imem_wdata, e.data);
                    check_eq("wmask", {28'b0, imem_wmask}, 32'hF);
                end
            end
            if (cpu_restart) restart_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs();
        check_eq("rst_pause", cpu_pause, 1);
        check_eq("rst_ready", rx_ready, 0);
        check_eq("rst_we", imem_we, 0);
        check_eq("rst_restart", cpu_restart, 0);
        check_eq("rst_busy", boot_busy, 0);
        check_eq("rst_err", boot_err, 0);
        check_eq("rst_waddr", imem_waddr, BASE);
        check_eq("rst_wdata", imem_wdata, 0);
        check_eq("rst_wmask", {28'b0, imem_wmask}, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (!rx_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!rx_ready) check_eq("rx_ready_timeout", rx_ready, 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_all(input bit toggle);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (toggle && i > 0) begin
                @(posedge clk);
                #1;
            end
            send_byte(tx_q[i]);
        end
        tx_q.delete();
    endtask

    task automatic pulse_req();
        boot_req = 1'b1;
        @(posedge clk);
        #1;
        boot_req = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
    endtask

    // One complete load of n words taken from words_q.
    task automatic run_load(input logic [31:0] n, input bit req, input bit toggle, input bit bad);
        int we0;
        int rs0;
        int lat;
        bit ok;
`ifdef IMEM_BOOT_CHECKSUM_EN
        logic [31:0] sum = '0;
`endif
        if (req) pulse_req();
        we0 = we_cnt;
        rs0 = restart_cnt;
        push_word(n);
        send_all(toggle);
        if (n > SIZE) begin
            @(negedge clk);
            check_eq("ovf_err", boot_err, 1);
            check_eq("ovf_ready", rx_ready, 0);
            check_eq("ovf_busy", boot_busy, 0);
            check_eq("ovf_pause", cpu_pause, 1);
            repeat (3) @(negedge clk);
            check_eq("ovf_no_we", 32'(we_cnt - we0), 0);
            check_eq("ovf_err_hold", boot_err, 1);
            @(posedge clk);
            #1;
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back('{addr: BASE + 32'(4 * i), data: words_q[i]});
            push_word(words_q[i]);
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum = sum + words_q[i];
`endif
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        push_word(bad ? sum + 32'd1 : sum);
        lat = 0;
`else
        lat = (n != 0) ? 1 : 0;
`endif
        send_all(toggle);
        ok = !bad;
        @(negedge clk);
        if (lat == 1) begin
            check_eq("last_we", imem_we, 1);
            check_eq("restart_early", cpu_restart, 0);
            @(negedge clk);
        end
        if (ok) begin
            check_eq("restart", cpu_restart, 1);
            check_eq("pause_done", cpu_pause, 1);
            @(negedge clk);
            check_eq("restart_end", cpu_restart, 0);
            check_eq("pause_idle", cpu_pause, 0);
            check_eq("busy_idle", boot_busy, 0);
        end else begin
            check_eq("csum_err", boot_err, 1);
            check_eq("csum_ready", rx_ready, 0);
            check_eq("csum_restart", cpu_restart, 0);
            repeat (3) @(negedge clk);
        end
        check_eq("we_count", 32'(we_cnt - we0), n);
        check_eq("restart_count", 32'(restart_cnt - rs0), {31'b0, ok});
        check_eq("exp_empty", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic recover();
        pulse_req();
        @(negedge clk);
        check_eq("rec_busy", boot_busy, 1);
        check_eq("rec_err", boot_err, 0);
        check_eq("rec_ready", rx_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        boot_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("ready_pre", rx_ready, 0);
        @(negedge clk);
        check_eq("ready_post", rx_ready, 1);
        check_eq("pause_hdr", cpu_pause, 1);
        @(posedge clk);
        #1;

        // Auto-boot load of two words.
        words_q = '{32'h0000_0013, 32'h0000_006F};
        run_load(32'd2, 1'b0, 1'b0, 1'b0);

        // Empty image: restart right after the header.
        words_q.delete();
        run_load(32'd0, 1'b1, 1'b0, 1'b0);

        // Oversized header, then recover into HDR.
        run_load(32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
        recover();
        words_q = '{32'hDEAD_BEEF};
        run_load(32'd1, 1'b0, 1'b1, 1'b0);

        // Boundary: first illegal count, then the largest legal one.
        run_load(32'(SIZE) + 32'd1, 1'b1, 1'b0, 1'b0);
        recover();
        words_q.delete();
        for (int i = 0; i < int'(SIZE); i++) words_q.push_back($urandom);
        run_load(32'(SIZE), 1'b0, 1'b0, 1'b0);

`ifdef IMEM_BOOT_CHECKSUM_EN
        words_q = '{32'h0000_0013};
        run_load(32'd1, 1'b1, 1'b0, 1'b0);
        run_load(32'd1, 1'b1, 1'b0, 1'b1);
        recover();
        run_load(32'd1, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized loads, half of them with rx_valid toggling.
        for (int k = 0; k < 12; k++) begin
            int unsigned n;
            n = $urandom_range(0, 6);
            words_q.delete();
            for (int i = 0; i < int'(n); i++) words_q.push_back($urandom);
            run_load(32'(n), 1'b1, bit'(k % 2), 1'b0);
        end

        // Reset after six data bytes of a three-word load.
        pulse_req();
        words_q = '{$urandom, $urandom, $urandom};
        exp_q.push_back('{addr: BASE, data: words_q[0]});
        push_word(32'd3);
        push_word(words_q[0]);
        tx_q.push_back(words_q[1][7:0]);
        tx_q.push_back(words_q[1][15:8]);
        send_all(1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        check_eq("rst_first_word", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        words_q = '{$urandom, $urandom};
        run_load(32'd2, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-load controller for the instruction memory. It receives a length-prefixed byte stream, such as one from a UART receiver. While loading, it holds the CPU paused, assembles little-endian 32-bit words and writes them into instruction memory through a dedicated write port. When the load completes, it releases the CPU with a restart pulse. It sits between the serial receiver, the instruction memory write side and the core's `l_pause` input.

## Interface
- `SIZE`, 1024: instruction memory depth in 32-bit words; the largest legal word count.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first loaded word; must be word aligned.
- `AUTO_BOOT`, 1: if 1, enter loading straight after reset; if 0, wait in IDLE for `boot_req`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `boot_req` in 1: starts a load from IDLE, DONE or ERROR; sampled on each clock.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: controller accepts a byte this cycle.
- `imem_we` out 1: one-cycle write strobe to instruction memory.
- `imem_waddr` out 32: byte address of the write.
- `imem_wdata` out 32: assembled word.
- `imem_wmask` out 4: byte enables; 4'hF whenever `imem_we` is high, else 4'h0.
- `cpu_pause` out 1: drives the core's `l_pause`.
- `cpu_restart` out 1: one-cycle pulse; the core reloads its PC to `BASE_ADDR`.
- `boot_busy` out 1: high in HDR, DATA and CSUM.
- `boot_err` out 1: high in ERROR.

## Operation
- States:
  - IDLE: `cpu_pause`=0.
  - HDR: receives the 4-byte word count N, little-endian.
  - DATA: receives 4·N bytes.
  - CSUM: only with the checksum macro.
  - DONE: lasts one cycle.
  - ERROR.
- A byte is accepted when `rx_valid && rx_ready`. `rx_ready`=1 exactly in HDR, DATA and CSUM.
- Byte assembly:
  - A 2-bit lane counter selects the byte position; the first byte goes to bits [7:0].
  - The counter wraps 3→0 after the fourth byte.
- HDR → DATA when the fourth header byte is accepted. Special header values:
  - N=0: go directly to DONE, or to CSUM when checksum is enabled.
  - N>`SIZE`: go to ERROR and write nothing.
- In DATA, every completed word produces one write at the current address. The address starts at `BASE_ADDR` and increments by 4 after each write. The word counter counts down from N.
- The last word's write moves the state to CSUM or DONE.
- DONE: pulses `cpu_restart`, then moves to IDLE.
- ERROR:
  - Holds `cpu_pause`=1 and `rx_ready`=0.
  - Stays there until `boot_req`, which re-enters HDR.
- `boot_req` handling:
  - In IDLE or DONE it enters HDR.
  - In HDR, DATA or CSUM it is ignored.
- `cpu_pause`=1 in every state except IDLE.
- Arithmetic:
  - The word count is 32 bits, compared unsigned against `SIZE`.
  - Address arithmetic wraps modulo 2^32; this cannot be reached with legal N.

## Timing
- Reset values:
  - `cpu_pause`=1.
  - `rx_ready`, `imem_we`, `cpu_restart`, `boot_busy` and `boot_err` = 0.
  - `imem_waddr`=`BASE_ADDR`.
  - `imem_wdata`=0 and `imem_wmask`=0.
- State after reset is HDR if `AUTO_BOOT`, else IDLE. `rx_ready` rises on the first clock after reset release.
- Write latency: `imem_we` goes high on the cycle after the fourth byte of a word is accepted. It lasts one cycle, and address and data are stable in that cycle.
- Throughput: one byte per cycle, with no bubbles between words.
- The `cpu_restart` pulse occurs on the cycle after the final write or the final checksum byte. `cpu_pause` falls on the following cycle, in IDLE.
- If `rst` is asserted mid-load, all state is lost and the controller returns to its reset state. Partially written memory is not cleared.

## Configuration
- `IMEM_BOOT_CHECKSUM_EN` defined:
  - After DATA, a CSUM state accepts 4 more bytes, little-endian.
  - They are compared with the modulo-2^32 sum of all written words.
  - Match → DONE; mismatch → ERROR, with no `cpu_restart`.
- Not defined: CSUM and the accumulator are absent, and the last data word goes directly to DONE.

## Structure
- Package `imem_boot_pkg`:
  - state encoding (IDLE, HDR, DATA, CSUM, DONE, ERROR);
  - header byte count (4);
  - full-word mask constant 4'hF.
- Sub-module `imem_word_assembler`: lane counter plus 32-bit shift/insert register, with a word-complete pulse. It is reused for the header, data and checksum.

## Test plan
- `AUTO_BOOT`=1; send header 02 00 00 00, then 13 00 00 00, 6F 00 00 00:
  - writes 0x00000013 @0x0 and 0x0000006F @0x4;
  - `cpu_restart` pulse, then `cpu_pause`=0.
- Header FF FF 00 00 with `SIZE`=1024 → ERROR:
  - no `imem_we`;
  - `rx_ready`=0 and `boot_err`=1;
  - `boot_req` returns the controller to HDR.
- `rx_valid` toggling every other cycle during DATA → identical written words; exactly one `imem_we` per 4 accepted bytes.
- `rst` asserted after 6 data bytes → all outputs at reset values in the same cycle; the load restarts from the header.
- Checksum enabled, N=1, word 0x00000013:
  - trailer 13 00 00 00 → DONE;
  - trailer 14 00 00 00 → ERROR, and `cpu_restart` never pulses.
- Header 00 00 00 00 → no writes; `cpu_restart` follows on the next cycle.
